// File: rtl/lift_call_scheduler_if.sv
// Call-scheduler <-> lift-controller bus. The scheduler takes the slave view.
// Build option LIFT_SCHED_DOOR_HOLD_EN adds the door_hold input.
interface lift_call_scheduler_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
);
  logic [NUM_FLOORS-1:0] call_btn;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  arrived;
`ifdef LIFT_SCHED_DOOR_HOLD_EN
  logic                  door_hold;
`endif
  logic [FLOOR_W-1:0]    target;
  logic                  target_valid;
  logic                  dir_up;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;

`ifdef LIFT_SCHED_DOOR_HOLD_EN
  modport master (
    output call_btn, cur_floor, arrived, door_hold,
    input  target, target_valid, dir_up, door_open, pending
  );
  modport slave (
    input  call_btn, cur_floor, arrived, door_hold,
    output target, target_valid, dir_up, door_open, pending
  );
`else
  modport master (
    output call_btn, cur_floor, arrived,
    input  target, target_valid, dir_up, door_open, pending
  );
  modport slave (
    input  call_btn, cur_floor, arrived,
    output target, target_valid, dir_up, door_open, pending
  );
`endif
endinterface

// File: rtl/lift_call_scheduler.sv
// SCAN-policy call scheduler: latches call-button edges, picks the next target floor, runs door dwell.
// Build option LIFT_SCHED_DOOR_HOLD_EN adds a door_hold input that keeps the door open in SERVE.
module lift_call_scheduler #(
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_W      = 2,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  lift_call_scheduler_if.slave io_bus
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_SERVE     = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ACT_HOLD  = 3'd0,
    ACT_DWELL = 3'd1,
    ACT_SERVE = 3'd2,
    ACT_UP    = 3'd3,
    ACT_DOWN  = 3'd4,
    ACT_IDLE  = 3'd5
  } act_t;

  state_t                r_state;
  logic [NUM_FLOORS-1:0] r_btn_q;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [FLOOR_W-1:0]    r_target;
  logic                  r_target_valid;
  logic                  r_dir_up;
  logic                  r_door_open;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_floor_ok;
  logic [NUM_FLOORS-1:0] w_cur_oh;
  logic [NUM_FLOORS-1:0] w_tgt_oh;
  logic [NUM_FLOORS-1:0] w_edge;
  logic [NUM_FLOORS-1:0] w_pend_nxt;
  logic                  w_here;
  logic                  w_arrive_hit;
  logic                  w_up_found;
  logic [FLOOR_W-1:0]    w_up_floor;
  logic                  w_dn_found;
  logic [FLOOR_W-1:0]    w_dn_floor;
  logic                  w_hold;
  act_t                  w_act;

`ifdef LIFT_SCHED_DOOR_HOLD_EN
  assign w_hold = io_bus.door_hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_floor_ok = int'(io_bus.cur_floor) < NUM_FLOORS;

  always_comb begin
    w_cur_oh = '0;
    w_tgt_oh = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_cur_oh[i] = (int'(io_bus.cur_floor) == i);
      w_tgt_oh[i] = (int'(r_target) == i);
    end
  end

  // The floor being served ignores fresh presses until the door cycle ends.
  assign w_edge       = io_bus.call_btn & ~r_btn_q &
                        ((r_state == ST_SERVE) ? ~w_tgt_oh : {NUM_FLOORS{1'b1}});
  assign w_pend_nxt   = r_pending | w_edge;
  assign w_here       = |(r_pending & w_cur_oh);
  assign w_arrive_hit = io_bus.arrived && (io_bus.cur_floor == r_target);

  // Up: lowest pending floor above the car. Down: highest pending floor below it.
  always_comb begin
    w_up_found = 1'b0;
    w_up_floor = '0;
    w_dn_found = 1'b0;
    w_dn_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (r_pending[i] && (i > int'(io_bus.cur_floor))) begin
        w_up_found = 1'b1;
        w_up_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (r_pending[i] && (i < int'(io_bus.cur_floor))) begin
        w_dn_found = 1'b1;
        w_dn_floor = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    w_act = ACT_HOLD;
    if (w_floor_ok) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_here)          w_act = ACT_SERVE;
          else if (w_up_found) w_act = ACT_UP;
          else if (w_dn_found) w_act = ACT_DOWN;
          else                 w_act = ACT_IDLE;
        end
        ST_MOVE_UP: begin
          if (w_arrive_hit)    w_act = ACT_SERVE;
          else if (w_up_found) w_act = ACT_UP;
          else if (w_dn_found) w_act = ACT_DOWN;
          else                 w_act = ACT_IDLE;
        end
        ST_MOVE_DOWN: begin
          if (w_arrive_hit)    w_act = ACT_SERVE;
          else if (w_dn_found) w_act = ACT_DOWN;
          else if (w_up_found) w_act = ACT_UP;
          else                 w_act = ACT_IDLE;
        end
        ST_SERVE: begin
          if (w_hold || (r_cnt != '0)) w_act = ACT_DWELL;
          else if (w_here)             w_act = ACT_SERVE;
          else if (r_dir_up) begin
            if (w_up_found)      w_act = ACT_UP;
            else if (w_dn_found) w_act = ACT_DOWN;
            else                 w_act = ACT_IDLE;
          end else begin
            if (w_dn_found)      w_act = ACT_DOWN;
            else if (w_up_found) w_act = ACT_UP;
            else                 w_act = ACT_IDLE;
          end
        end
        default: w_act = ACT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_btn_q        <= '0;
      r_pending      <= '0;
      r_target       <= '0;
      r_target_valid <= 1'b0;
      r_dir_up       <= 1'b1;
      r_door_open    <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_btn_q   <= io_bus.call_btn;
      r_pending <= w_pend_nxt;
      unique case (w_act)
        ACT_HOLD: ;
        ACT_DWELL: begin
          r_cnt <= w_hold ? CNT_LOAD : (r_cnt - CNT_W'(1));
        end
        ACT_SERVE: begin
          // Clearing the served floor overrides a same-cycle press on it.
          r_state        <= ST_SERVE;
          r_pending      <= w_pend_nxt & ~w_cur_oh;
          r_target       <= io_bus.cur_floor;
          r_target_valid <= 1'b0;
          r_door_open    <= 1'b1;
          r_cnt          <= CNT_LOAD;
        end
        ACT_UP: begin
          r_state        <= ST_MOVE_UP;
          r_dir_up       <= 1'b1;
          r_target       <= w_up_floor;
          r_target_valid <= 1'b1;
          r_door_open    <= 1'b0;
        end
        ACT_DOWN: begin
          r_state        <= ST_MOVE_DOWN;
          r_dir_up       <= 1'b0;
          r_target       <= w_dn_floor;
          r_target_valid <= 1'b1;
          r_door_open    <= 1'b0;
        end
        ACT_IDLE: begin
          r_state        <= ST_IDLE;
          r_target_valid <= 1'b0;
          r_door_open    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.target       = r_target;
  assign io_bus.target_valid = r_target_valid;
  assign io_bus.dir_up       = r_dir_up;
  assign io_bus.door_open    = r_door_open;
  assign io_bus.pending      = r_pending;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Self-checking bench for lift_call_scheduler: vector table plus hand-written reset and door-hold sequences.
module tb_lift_call_scheduler;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] fl;
    logic       arr;
    logic [8:0] outs;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] outs;
  } sb_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  sb_t  sb_q[$];
  vec_t vecs[$];

  lift_call_scheduler_if #(.NUM_FLOORS(4), .FLOOR_W(2)) ifc ();

  lift_call_scheduler #(
    .NUM_FLOORS  (4),
    .FLOOR_W     (2),
    .DWELL_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {target, target_valid, dir_up, door_open, pending}.
  function automatic logic [8:0] ex(logic [1:0] t, logic v, logic d, logic o, logic [3:0] p);
    return {t, v, d, o, p};
  endfunction

  function automatic vec_t mk(logic [3:0] b, logic [1:0] f, logic a, logic [8:0] e);
    vec_t r;
    r.btn  = b;
    r.fl   = f;
    r.arr  = a;
    r.outs = e;
    return r;
  endfunction

  task automatic check_out();
    sb_t        e;
    logic [8:0] act;
    act = {ifc.target, ifc.target_valid, ifc.dir_up, ifc.door_open, ifc.pending};
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    if (act !== e.outs) begin
      n_errors++;
      $display("FAIL %s: got tgt=%0d vld=%b dir=%b door=%b pend=%b, want tgt=%0d vld=%b dir=%b door=%b pend=%b",
               e.name, act[8:7], act[6], act[5], act[4], act[3:0],
               e.outs[8:7], e.outs[6], e.outs[5], e.outs[4], e.outs[3:0]);
    end
  endtask

  task automatic drive_cycle(input logic [3:0] b, input logic [1:0] f, input logic a,
                             input string name, input logic [8:0] e);
    sb_t s;
    @(negedge clk);
    ifc.call_btn  = b;
    ifc.cur_floor = f;
    ifc.arrived   = a;
    s.name = name;
    s.outs = e;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    sb_t s;
    n_checks = 0;
    n_errors = 0;
    reset         = 1'b0;
    ifc.call_btn  = '0;
    ifc.cur_floor = '0;
    ifc.arrived   = 1'b0;
`ifdef LIFT_SCHED_DOOR_HOLD_EN
    ifc.door_hold = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single call to floor 3, arrival, dwell, back to idle
    vecs.push_back(mk(4'b0000, 2'd0, 1'b0, ex(2'd0, 0, 1, 0, 4'b0000)));
    vecs.push_back(mk(4'b1000, 2'd0, 1'b0, ex(2'd0, 0, 1, 0, 4'b1000)));
    vecs.push_back(mk(4'b0000, 2'd0, 1'b0, ex(2'd3, 1, 1, 0, 4'b1000)));
    vecs.push_back(mk(4'b0000, 2'd1, 1'b0, ex(2'd3, 1, 1, 0, 4'b1000)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b1, ex(2'd3, 0, 1, 1, 4'b0000)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd3, 0, 1, 1, 4'b0000)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd3, 0, 1, 1, 4'b0000)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd3, 0, 1, 1, 4'b0000)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd3, 0, 1, 0, 4'b0000)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd3, 0, 1, 0, 4'b0000)));
    // En-route pickup at floor 2 while heading for 3; off-target arrival ignored
    vecs.push_back(mk(4'b1000, 2'd0, 1'b0, ex(2'd3, 0, 1, 0, 4'b1000)));
    vecs.push_back(mk(4'b0000, 2'd0, 1'b0, ex(2'd3, 1, 1, 0, 4'b1000)));
    vecs.push_back(mk(4'b0000, 2'd1, 1'b1, ex(2'd3, 1, 1, 0, 4'b1000)));
    vecs.push_back(mk(4'b0100, 2'd1, 1'b0, ex(2'd3, 1, 1, 0, 4'b1100)));
    vecs.push_back(mk(4'b0000, 2'd1, 1'b0, ex(2'd2, 1, 1, 0, 4'b1100)));
    vecs.push_back(mk(4'b0000, 2'd2, 1'b1, ex(2'd2, 0, 1, 1, 4'b1000)));
    vecs.push_back(mk(4'b0000, 2'd2, 1'b1, ex(2'd2, 0, 1, 1, 4'b1000)));
    vecs.push_back(mk(4'b0000, 2'd2, 1'b0, ex(2'd2, 0, 1, 1, 4'b1000)));
    vecs.push_back(mk(4'b0000, 2'd2, 1'b0, ex(2'd2, 0, 1, 1, 4'b1000)));
    vecs.push_back(mk(4'b0000, 2'd2, 1'b0, ex(2'd3, 1, 1, 0, 4'b1000)));
    // Reversal: serve 3 first, then sweep down to 0
    vecs.push_back(mk(4'b0001, 2'd2, 1'b0, ex(2'd3, 1, 1, 0, 4'b1001)));
    vecs.push_back(mk(4'b0000, 2'd2, 1'b0, ex(2'd3, 1, 1, 0, 4'b1001)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b1, ex(2'd3, 0, 1, 1, 4'b0001)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd3, 0, 1, 1, 4'b0001)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd3, 0, 1, 1, 4'b0001)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd3, 0, 1, 1, 4'b0001)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd0, 1, 0, 0, 4'b0001)));
    vecs.push_back(mk(4'b0000, 2'd2, 1'b0, ex(2'd0, 1, 0, 0, 4'b0001)));
    vecs.push_back(mk(4'b0000, 2'd1, 1'b0, ex(2'd0, 1, 0, 0, 4'b0001)));
    vecs.push_back(mk(4'b0000, 2'd0, 1'b1, ex(2'd0, 0, 0, 1, 4'b0000)));
    vecs.push_back(mk(4'b0000, 2'd0, 1'b0, ex(2'd0, 0, 0, 1, 4'b0000)));
    vecs.push_back(mk(4'b0000, 2'd0, 1'b0, ex(2'd0, 0, 0, 1, 4'b0000)));
    vecs.push_back(mk(4'b0000, 2'd0, 1'b0, ex(2'd0, 0, 0, 1, 4'b0000)));
    vecs.push_back(mk(4'b0000, 2'd0, 1'b0, ex(2'd0, 0, 0, 0, 4'b0000)));
    // Call at the current floor, then the held button must not re-arm it
    vecs.push_back(mk(4'b0010, 2'd1, 1'b0, ex(2'd0, 0, 0, 0, 4'b0010)));
    vecs.push_back(mk(4'b0010, 2'd1, 1'b0, ex(2'd1, 0, 0, 1, 4'b0000)));
    vecs.push_back(mk(4'b0010, 2'd1, 1'b0, ex(2'd1, 0, 0, 1, 4'b0000)));
    vecs.push_back(mk(4'b0010, 2'd1, 1'b0, ex(2'd1, 0, 0, 1, 4'b0000)));
    vecs.push_back(mk(4'b0010, 2'd1, 1'b0, ex(2'd1, 0, 0, 1, 4'b0000)));
    vecs.push_back(mk(4'b0010, 2'd1, 1'b0, ex(2'd1, 0, 0, 0, 4'b0000)));
    vecs.push_back(mk(4'b0010, 2'd1, 1'b0, ex(2'd1, 0, 0, 0, 4'b0000)));
    vecs.push_back(mk(4'b0000, 2'd1, 1'b1, ex(2'd1, 0, 0, 0, 4'b0000)));
    // Calls both ways from idle: up wins even though dir_up was 0
    vecs.push_back(mk(4'b1001, 2'd1, 1'b0, ex(2'd1, 0, 0, 0, 4'b1001)));
    vecs.push_back(mk(4'b0000, 2'd1, 1'b0, ex(2'd3, 1, 1, 0, 4'b1001)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b1, ex(2'd3, 0, 1, 1, 4'b0001)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd3, 0, 1, 1, 4'b0001)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd3, 0, 1, 1, 4'b0001)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd3, 0, 1, 1, 4'b0001)));
    vecs.push_back(mk(4'b0000, 2'd3, 1'b0, ex(2'd0, 1, 0, 0, 4'b0001)));

    for (int i = 0; i < vecs.size(); i++)
      drive_cycle(vecs[i].btn, vecs[i].fl, vecs[i].arr, $sformatf("vec%0d", i), vecs[i].outs);

    // Asynchronous reset mid-run with pending=0110 and the door open
    drive_cycle(4'b0111, 2'd0, 1'b0, "rst_setup0", ex(2'd0, 0, 0, 0, 4'b0111));
    drive_cycle(4'b0000, 2'd0, 1'b0, "rst_setup1", ex(2'd0, 0, 0, 1, 4'b0110));
    #2;
    reset = 1'b0;
    #1;
    s.name = "async_reset";
    s.outs = ex(2'd0, 0, 1, 0, 4'b0000);
    sb_q.push_back(s);
    check_out();
    @(negedge clk);
    reset = 1'b1;
    drive_cycle(4'b0000, 2'd0, 1'b0, "post_reset_idle", ex(2'd0, 0, 1, 0, 4'b0000));
    drive_cycle(4'b0100, 2'd0, 1'b0, "post_reset_call", ex(2'd0, 0, 1, 0, 4'b0100));
    drive_cycle(4'b0000, 2'd0, 1'b0, "post_reset_move", ex(2'd2, 1, 1, 0, 4'b0100));

`ifdef LIFT_SCHED_DOOR_HOLD_EN
    drive_cycle(4'b0000, 2'd2, 1'b1, "hold_enter", ex(2'd2, 0, 1, 1, 4'b0000));
    ifc.door_hold = 1'b1;
    for (int i = 0; i < 10; i++)
      drive_cycle(4'b0000, 2'd2, (i == 5), $sformatf("hold%0d", i), ex(2'd2, 0, 1, 1, 4'b0000));
    @(negedge clk);
    ifc.door_hold = 1'b0;
    for (int i = 0; i < 3; i++)
      drive_cycle(4'b0000, 2'd2, 1'b0, $sformatf("release%0d", i), ex(2'd2, 0, 1, 1, 4'b0000));
    drive_cycle(4'b0000, 2'd2, 1'b0, "release_close", ex(2'd2, 0, 1, 0, 4'b0000));
    @(negedge clk);
    ifc.door_hold = 1'b1;
    drive_cycle(4'b0000, 2'd2, 1'b0, "hold_in_idle", ex(2'd2, 0, 1, 0, 4'b0000));
    ifc.door_hold = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
